// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer
//
// Time-shares one WIDTH-bit NAND unit to evaluate a selected logic
// function on two operands. Each operation is broken into a fixed sequence
// of NAND steps, one per clock, with a start/busy/done handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous, active-low reset
//   start   request, sampled only while idle
//   op      operation select (sampled with start)
//             000 NAND, 001 AND, 010 OR, 011 XOR, 100 NOT A,
//             101 NOR, 110 XNOR, 111 illegal
//   a, b    operands (sampled with start)
//   busy    high from accept until the return to idle
//   done    one-cycle pulse, result valid
//   err     illegal-op flag, valid with done, held until next accept
//   result  registered result, held until overwritten at completion
//   step    index of the NAND step being computed (0 when not executing)

// Shared bitwise NAND unit.
module nand_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);
    assign z = ~(x & y);
endmodule

module nand_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       step
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] t1, t2, t3;
    logic [2:0]       n_steps;
    logic [WIDTH-1:0] nand_a, nand_b, nand_y;

    nand_unit #(.WIDTH(WIDTH)) u_nand (
        .x (nand_a),
        .y (nand_b),
        .z (nand_y)
    );

    // Number of NAND steps each operation needs; the final step's output
    // is the result.
    always_comb begin
        n_steps = 3'd1;
        case (op_q)
            OP_NAND: n_steps = 3'd1;
            OP_AND:  n_steps = 3'd2;
            OP_OR:   n_steps = 3'd3;
            OP_XOR:  n_steps = 3'd4;
            OP_NOT:  n_steps = 3'd1;
            OP_NOR:  n_steps = 3'd4;
            OP_XNOR: n_steps = 3'd5;
            default: n_steps = 3'd1;
        endcase
    end

    // Operand routing into the shared NAND unit for the current step.
    // Step outputs land in t1, t2, t3, then t1 again for step 4 (XOR/XNOR
    // no longer need the old t1 by then), so NOR's inverter reads t3 and
    // XNOR's inverter reads t1. Inputs are held at zero outside EXEC.
    always_comb begin
        nand_a = '0;
        nand_b = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_NAND: begin
                    nand_a = a_q;
                    nand_b = b_q;
                end
                OP_AND: begin
                    if (step == 3'd1) begin
                        nand_a = a_q;
                        nand_b = b_q;
                    end else begin
                        nand_a = t1;
                        nand_b = t1;
                    end
                end
                OP_OR, OP_NOR: begin
                    case (step)
                        3'd1:    begin nand_a = a_q; nand_b = a_q; end
                        3'd2:    begin nand_a = b_q; nand_b = b_q; end
                        3'd3:    begin nand_a = t1;  nand_b = t2;  end
                        default: begin nand_a = t3;  nand_b = t3;  end
                    endcase
                end
                OP_XOR, OP_XNOR: begin
                    case (step)
                        3'd1:    begin nand_a = a_q; nand_b = b_q; end
                        3'd2:    begin nand_a = a_q; nand_b = t1;  end
                        3'd3:    begin nand_a = b_q; nand_b = t1;  end
                        3'd4:    begin nand_a = t2;  nand_b = t3;  end
                        default: begin nand_a = t1;  nand_b = t1;  end
                    endcase
                end
                OP_NOT: begin
                    nand_a = a_q;
                    nand_b = a_q;
                end
                default: begin
                    nand_a = '0;
                    nand_b = '0;
                end
            endcase
        end
    end

    // Sequencer FSM with registered handshake outputs. An illegal op skips
    // EXEC entirely and completes with err set and a zero result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            t1     <= '0;
            t2     <= '0;
            t3     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            step   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        busy <= 1'b1;
                        if (op == OP_ILL) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
                        end else begin
                            state <= EXEC;
                            err   <= 1'b0;
                            step  <= 3'd1;
                        end
                    end
                end
                EXEC: begin
                    case (step)
                        3'd1:    t1 <= nand_y;
                        3'd2:    t2 <= nand_y;
                        3'd3:    t3 <= nand_y;
                        3'd4:    t1 <= nand_y;
                        default: ;
                    endcase
                    if (step == n_steps) begin
                        result <= nand_y;
                        state  <= DONE;
                        done   <= 1'b1;
                        step   <= '0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    step  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb_nand_op_sequencer
//
// Self-checking bench for nand_op_sequencer (WIDTH=4). A behavioural model
// tracks "edges since accept" for the current operation and computes the
// result directly with ordinary logic operators; a compare process checks
// every DUT output against it on every falling edge. Directed scenarios
// add hand-computed literal expectations.

module tb_nand_op_sequencer;

    localparam int WIDTH = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op    = 3'd0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [2:0]       step;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    nand_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .step   (step)
    );

    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Reference function straight from the logic definitions.
    function automatic logic [WIDTH-1:0] refFunc(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    return ~(x & y);
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~x;
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return '0;
        endcase
    endfunction

    // Edges from accept until DONE is entered (NAND step count; 0 if illegal).
    function automatic int refEdges(input logic [2:0] o);
        case (o)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 3;
            3'd3:    return 4;
            3'd4:    return 1;
            3'd5:    return 4;
            3'd6:    return 5;
            default: return 0;
        endcase
    endfunction

    // Model state: active operation, edges since accept, edges to DONE.
    bit               m_active = 1'b0;
    int               m_cnt    = 0;
    int               m_d      = 0;
    logic [WIDTH-1:0] m_final  = '0;
    logic [WIDTH-1:0] m_result = '0;
    bit               m_err    = 1'b0;

    always @(posedge clk) begin : model
        bit               n_active;
        int               n_cnt, n_d;
        logic [WIDTH-1:0] n_final, n_result;
        bit               n_err;
        n_active = m_active; n_cnt = m_cnt; n_d = m_d;
        n_final  = m_final;  n_result = m_result; n_err = m_err;
        if (!rst_n) begin
            n_active = 1'b0; n_cnt = 0; n_result = '0; n_err = 1'b0;
        end else begin
            if (n_active) begin
                n_cnt++;
                if (n_cnt > n_d) n_active = 1'b0;
            end else if (start) begin
                n_active = 1'b1;
                n_cnt    = 0;
                n_d      = refEdges(op);
                n_final  = refFunc(op, a, b);
                n_err    = (op == 3'b111);
            end
            if (n_active && n_cnt == n_d) n_result = n_final;
        end
        m_active <= n_active; m_cnt <= n_cnt; m_d <= n_d;
        m_final  <= n_final;  m_result <= n_result; m_err <= n_err;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("busy", busy, m_active);
            checkOutput("done", done, (m_active && m_cnt == m_d));
            checkOutput("err", err, m_err);
            checkOutput("result", result, m_result);
            checkOutput("step", step, (m_active && m_cnt < m_d) ? m_cnt + 1 : 0);
        end
    end

    // Presents one request, then measures edges from accept to done and
    // checks the literal result/err and that done drops after one cycle.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] exp_res,
                                 input int exp_edges, input logic exp_err,
                                 input string nm);
        int edges;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        @(negedge clk);
        while (done !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({nm, "_latency"}, edges, exp_edges);
        checkOutput({nm, "_result"}, result, exp_res);
        checkOutput({nm, "_err"}, err, exp_err);
        @(negedge clk);
        checkOutput({nm, "_done_width"}, done, 1'b0);
        checkOutput({nm, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin : stim
        int dn;
        int guard;
        int cyc;
        int last_acc;
        int n_acc;
        logic prev_busy, prev_done;

        // Reset held two cycles with start asserted.
        rst_n = 1'b0; start = 1'b1; op = 3'd3; a = 4'hC; b = 4'hA;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_result", result, 4'b0000);
        checkOutput("rst_step", step, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;

        // Every op on a=1100, b=1010.
        applyStimulus(3'd0, 4'b1100, 4'b1010, 4'b0111, 1, 1'b0, "nand");
        applyStimulus(3'd1, 4'b1100, 4'b1010, 4'b1000, 2, 1'b0, "and");
        applyStimulus(3'd2, 4'b1100, 4'b1010, 4'b1110, 3, 1'b0, "or");
        applyStimulus(3'd3, 4'b1100, 4'b1010, 4'b0110, 4, 1'b0, "xor");
        applyStimulus(3'd4, 4'b1100, 4'b1010, 4'b0011, 1, 1'b0, "not");
        applyStimulus(3'd5, 4'b1100, 4'b1010, 4'b0001, 4, 1'b0, "nor");
        applyStimulus(3'd6, 4'b1100, 4'b1010, 4'b1001, 5, 1'b0, "xnor");

        // Start pulses while busy must be ignored.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; a = 4'b1100; b = 4'b1010;
        @(posedge clk);
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            start = (i == 1 || i == 2);
            if (start) begin op = 3'd1; a = 4'b1111; end
            @(negedge clk);
            if (done === 1'b1) dn++;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        checkOutput("ignore_done_count", dn, 1);
        checkOutput("ignore_result", result, 4'b0110);

        // Illegal op, then a legal op clears err.
        applyStimulus(3'd7, 4'b1100, 4'b1010, 4'b0000, 0, 1'b1, "illegal");
        applyStimulus(3'd1, 4'b1111, 4'b0101, 4'b0101, 2, 1'b0, "and_after_ill");

        // Reset in the middle of an XNOR at step 3.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; a = 4'b1100; b = 4'b1010;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        @(negedge clk);
        while (step !== 3'd3 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midrst_reach_step3", step, 3'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        checkOutput("midrst_no_done", dn, 0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_result", result, 4'b0000);
        applyStimulus(3'd0, 4'b0000, 4'b1111, 4'b1111, 1, 1'b0, "nand_after_rst");

        // Continuous start with OR: accepts 5 apart, done 3 after accept.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd2; a = 4'($urandom); b = 4'($urandom);
        cyc = 0; last_acc = -100; n_acc = 0;
        prev_busy = 1'b0; prev_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                if (n_acc > 0) checkOutput("b2b_spacing", cyc - last_acc, 5);
                last_acc = cyc;
                n_acc++;
            end
            if (done === 1'b1 && prev_done !== 1'b1)
                checkOutput("b2b_done_delay", cyc - last_acc, 3);
            prev_busy = busy;
            prev_done = done;
            @(posedge clk); #1;
            a = 4'($urandom); b = 4'($urandom);
        end
        start = 1'b0;
        checkOutput("b2b_accept_count", n_acc, 6);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 39) != 0);
            start = ($urandom_range(0, 2) != 0);
            op    = 3'($urandom_range(0, 7));
            a     = 4'($urandom);
            b     = 4'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
